// File: rtl/snoop_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : snoop_arbiter
// Purpose  : Serializes snoop requests from two L1 coherence controllers.
//            A round-robin pick selects one requester g; its snoop is issued
//            on the AC channel of the other cache (t = ~g). The CR response
//            is collected and returned to g, followed by the 16-beat CD burst
//            when the response carries DataTransfer. At most one snoop is
//            outstanding at any time.
// Ports    : ACLK/ARESET            clock, async active-high reset
//            REQ_*                  per-cache snoop request in, one-hot accept
//            AC* / CR* / CD*        snoop channels to/from each cache
//            RSP_*                  latched CR response towards requester
//            RDATA_*                CD beats forwarded to requester
//            BUSY                   transaction in progress
//            PROTO_ERR              sticky CDLAST/beat-count mismatch flag
// Revision : 1.0 - initial release
// ============================================================================
module snoop_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic [1:0]          REQ_VALID,
   output logic [1:0]          REQ_READY,
   input  logic [2*ADDR_W-1:0] REQ_ADDR,
   input  logic [7:0]          REQ_SNOOP,
   input  logic [5:0]          REQ_PROT,
   output logic [1:0]          ACVALID,
   input  logic [1:0]          ACREADY,
   output logic [2*ADDR_W-1:0] ACADDR,
   output logic [7:0]          ACSNOOP,
   output logic [5:0]          ACPROT,
   input  logic [1:0]          CRVALID,
   output logic [1:0]          CRREADY,
   input  logic [9:0]          CRRESP,
   input  logic [1:0]          CDVALID,
   output logic [1:0]          CDREADY,
   input  logic [2*DATA_W-1:0] CDDATA,
   input  logic [1:0]          CDLAST,
   output logic                RSP_VALID,
   input  logic                RSP_READY,
   output logic                RSP_ID,
   output logic [4:0]          RSP_RESP,
   output logic                RDATA_VALID,
   input  logic                RDATA_READY,
   output logic [DATA_W-1:0]   RDATA,
   output logic                RDATA_LAST,
   output logic                BUSY,
   output logic                PROTO_ERR
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_AC_ISSUE = 3'd1,
      ST_CR_WAIT  = 3'd2,
      ST_RSP      = 3'd3,
      ST_CD_FWD   = 3'd4
   } state_t;

   localparam logic [3:0] C_LAST_BEAT = 4'd15;

   state_t              r_state;
   state_t              w_next_state;
   logic                r_g;
   logic                r_last_grant;
   logic [ADDR_W-1:0]   r_addr;
   logic [3:0]          r_snoop;
   logic [2:0]          r_prot;
   logic [4:0]          r_resp;
   logic [3:0]          r_beat_cnt;
   logic                r_proto_err;

   logic                w_t;
   logic                w_req_any;
   logic                w_pick;
   logic                w_ac_ready;
   logic                w_cr_valid;
   logic [4:0]          w_crresp;
   logic                w_cd_valid;
   logic                w_cd_last;
   logic [DATA_W-1:0]   w_cd_data;
   logic                w_last_beat;
   logic                w_cd_hs;

   // The snoop always targets the cache that did not request it.
   assign w_t         = ~r_g;
   assign w_req_any   = |REQ_VALID;
   // A tie goes to the cache that was not served last.
   assign w_pick      = (&REQ_VALID) ? ~r_last_grant : REQ_VALID[1];

   assign w_ac_ready  = w_t ? ACREADY[1] : ACREADY[0];
   assign w_cr_valid  = w_t ? CRVALID[1] : CRVALID[0];
   assign w_crresp    = w_t ? CRRESP[9:5] : CRRESP[4:0];
   assign w_cd_valid  = w_t ? CDVALID[1] : CDVALID[0];
   assign w_cd_last   = w_t ? CDLAST[1]  : CDLAST[0];
   assign w_cd_data   = w_t ? CDDATA[2*DATA_W-1:DATA_W] : CDDATA[DATA_W-1:0];
   assign w_last_beat = (r_beat_cnt == C_LAST_BEAT);
   assign w_cd_hs     = (r_state == ST_CD_FWD) && w_cd_valid && RDATA_READY;

   assign BUSY        = (r_state != ST_IDLE);
   assign PROTO_ERR   = r_proto_err;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      REQ_READY    = 2'b00;
      ACVALID      = 2'b00;
      ACADDR       = '0;
      ACSNOOP      = 8'h00;
      ACPROT       = 6'h00;
      CRREADY      = 2'b00;
      CDREADY      = 2'b00;
      RSP_VALID    = 1'b0;
      RSP_ID       = 1'b0;
      RSP_RESP     = 5'h00;
      RDATA_VALID  = 1'b0;
      RDATA        = '0;
      RDATA_LAST   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req_any) begin
               // Accept is held off while reset is applied so every output
               // reads 0 during reset regardless of the request inputs.
               REQ_READY[w_pick] = ~ARESET;
               w_next_state      = ST_AC_ISSUE;
            end
         end
         ST_AC_ISSUE: begin
            ACVALID[w_t] = 1'b1;
            if (w_t) begin
               ACADDR[2*ADDR_W-1:ADDR_W] = r_addr;
               ACSNOOP[7:4]              = r_snoop;
               ACPROT[5:3]               = r_prot;
            end else begin
               ACADDR[ADDR_W-1:0]        = r_addr;
               ACSNOOP[3:0]              = r_snoop;
               ACPROT[2:0]               = r_prot;
            end
            if (w_ac_ready) begin
               w_next_state = ST_CR_WAIT;
            end
         end
         ST_CR_WAIT: begin
            CRREADY[w_t] = 1'b1;
            if (w_cr_valid) begin
               w_next_state = ST_RSP;
            end
         end
         ST_RSP: begin
            RSP_VALID = 1'b1;
            RSP_ID    = r_g;
            RSP_RESP  = r_resp;
            if (RSP_READY) begin
               w_next_state = r_resp[0] ? ST_CD_FWD : ST_IDLE;
            end
         end
         ST_CD_FWD: begin
            // Zero-latency pass-through of the target's CD channel.
            RDATA_VALID  = w_cd_valid;
            RDATA        = w_cd_data;
            CDREADY[w_t] = RDATA_READY;
            RSP_ID       = r_g;
            RDATA_LAST   = w_last_beat;
            if (w_cd_hs && w_last_beat) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_g          <= 1'b0;
         r_last_grant <= 1'b1;
         r_addr       <= '0;
         r_snoop      <= 4'h0;
         r_prot       <= 3'h0;
         r_resp       <= 5'h00;
         r_beat_cnt   <= 4'h0;
         r_proto_err  <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && w_req_any) begin
            r_g     <= w_pick;
            r_addr  <= w_pick ? REQ_ADDR[2*ADDR_W-1:ADDR_W] : REQ_ADDR[ADDR_W-1:0];
            r_snoop <= w_pick ? REQ_SNOOP[7:4] : REQ_SNOOP[3:0];
            r_prot  <= w_pick ? REQ_PROT[5:3]  : REQ_PROT[2:0];
         end
         if ((r_state == ST_CR_WAIT) && w_cr_valid) begin
            r_resp <= w_crresp;
         end
         if ((r_state == ST_RSP) && RSP_READY) begin
            r_last_grant <= r_g;
            r_beat_cnt   <= 4'h0;
         end
         if (w_cd_hs) begin
            // The beat counter, not CDLAST, ends the burst; a disagreement
            // is only flagged.
            r_beat_cnt <= r_beat_cnt + 4'd1;
            if (w_cd_last != w_last_beat) begin
               r_proto_err <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire
